ps2_key_event_controller: RTL and testbench

Sequences the byte stream from the PS/2 keyboard receiver into complete key events. It resolves the scan-code set 2 prefixes 0xE0 (extended) and 0xF0 (break) into one event of {code, extended, release}. Events are buffered in a small FIFO and handed to downstream logic (display or CPU) over a valid/ready handshake. It sits between the PS/2 receiver's byte output and any consumer of keystrokes.

---
 rtl/ps2_key_event_controller_if.sv | 41 ++++
 rtl/ps2_key_event_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_ps2_key_event_controller.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_event_controller_if.sv
// ----------------------------------------------------------------------------
// ps2_key_event_controller_if
// Bundles the byte-side and event-side signals of ps2_key_event_controller.
//   master : environment side; drives received bytes, consumes key events
//   slave  : controller side; accepts bytes, presents buffered key events
// Signals:
//   rx_data/rx_valid/rx_error        byte stream and error strobe from receiver
//   event_code/extended/release      head event of the FIFO
//   event_valid/event_ready          consumer handshake
//   fifo_count, overflow             FIFO occupancy and sticky drop flag
//   clear_overflow                   synchronous clear of overflow
//   seq_error                        one-cycle pulse on rx error or prefix timeout
// ----------------------------------------------------------------------------
interface ps2_key_event_controller_if #(
  parameter int FIFO_DEPTH = 8
);
  logic [7:0]                    rx_data;
  logic                          rx_valid;
  logic                          rx_error;
  logic [7:0]                    event_code;
  logic                          event_extended;
  logic                          event_release;
  logic                          event_valid;
  logic                          event_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;
  logic                          clear_overflow;
  logic                          seq_error;

  modport master (
    output rx_data, rx_valid, rx_error, event_ready, clear_overflow,
    input  event_code, event_extended, event_release, event_valid,
           fifo_count, overflow, seq_error
  );

  modport slave (
    input  rx_data, rx_valid, rx_error, event_ready, clear_overflow,
    output event_code, event_extended, event_release, event_valid,
           fifo_count, overflow, seq_error
  );
endinterface

// File: rtl/ps2_key_event_controller.sv
// ----------------------------------------------------------------------------
// ps2_key_event_controller
// Turns the PS/2 scan-code set 2 byte stream into {code, extended, release}
// key events, buffers them in a FIFO and offers them over valid/ready.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    ps2_key_event_controller_if.slave (byte input, event output,
//          fifo_count, overflow/clear_overflow, seq_error)
// Parameters:
//   FIFO_DEPTH      buffered events, power of two, >= 2
//   TIMEOUT_CYCLES  max cycles between a prefix byte and its code byte (>= 2)
// Optional feature:
//   PS2_TYPEMATIC_FILTER_EN  when defined, auto-repeat makes of the key that
//                            is currently held down are suppressed.
// ----------------------------------------------------------------------------
module ps2_key_event_controller #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic                         clock,
  input logic                         reset,
  ps2_key_event_controller_if.slave   bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // Bytes that are keyboard status/replies rather than key codes.
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  logic [1:0]    state_r;
  logic [1:0]    state_next_s;
  logic [TW-1:0] tmo_cnt_r;
  logic          timeout_s;
  logic          push_s;
  logic          push_ext_s;
  logic          push_rel_s;
  logic          accept_s;
  logic [9:0]    entry_s;

  logic [9:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] rd_next_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic [CW-1:0] remain_s;
  logic          pop_s;
  logic          full_s;
  logic          wr_ok_s;
  logic          drop_s;
  logic [9:0]    head_r;
  logic [9:0]    head_next_s;
  logic          valid_r;
  logic          overflow_r;
  logic          seq_error_r;

  // Prefix decoding: next state and the event (if any) completed by this byte.
  always_comb begin
    state_next_s = state_r;
    push_s       = 1'b0;
    push_ext_s   = 1'b0;
    push_rel_s   = 1'b0;
    timeout_s    = 1'b0;
    if (bus.rx_error) begin
      state_next_s = ST_IDLE;
    end else if (bus.rx_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.rx_data == 8'hE0) begin
            state_next_s = ST_EXT;
          end else if (bus.rx_data == 8'hF0) begin
            state_next_s = ST_BRK;
          end else if (is_ignored(bus.rx_data)) begin
            state_next_s = ST_IDLE;
          end else begin
            push_s = 1'b1;
          end
        end
        ST_EXT: begin
          if (bus.rx_data == 8'hF0) begin
            state_next_s = ST_EXT_BRK;
          end else if (bus.rx_data == 8'hE0) begin
            state_next_s = ST_EXT;
          end else begin
            push_s       = 1'b1;
            push_ext_s   = 1'b1;
            state_next_s = ST_IDLE;
          end
        end
        ST_BRK: begin
          push_s       = 1'b1;
          push_rel_s   = 1'b1;
          state_next_s = ST_IDLE;
        end
        ST_EXT_BRK: begin
          push_s       = 1'b1;
          push_ext_s   = 1'b1;
          push_rel_s   = 1'b1;
          state_next_s = ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end else if ((state_r != ST_IDLE) && (tmo_cnt_r == TO_LAST)) begin
      // Prefix arrived but its code byte never did: abandon the sequence.
      state_next_s = ST_IDLE;
      timeout_s    = 1'b1;
    end else begin
      state_next_s = state_r;
    end
  end

  assign entry_s = {bus.rx_data, push_ext_s, push_rel_s};

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [7:0] held_code_r;
  logic       held_ext_r;
  logic       held_valid_r;
  logic       held_match_s;

  // Auto-repeat filter: a make equal to the held key is swallowed.
  always_comb begin
    held_match_s = held_valid_r && (held_code_r == bus.rx_data) &&
                   (held_ext_r == push_ext_s);
    if (push_s && !push_rel_s && held_match_s) begin
      accept_s = 1'b0;
    end else begin
      accept_s = push_s;
    end
  end

  // Held-key tracking; a make is remembered even if the FIFO drops it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held_code_r  <= 8'h00;
      held_ext_r   <= 1'b0;
      held_valid_r <= 1'b0;
    end else if (push_s && !push_rel_s) begin
      held_code_r  <= bus.rx_data;
      held_ext_r   <= push_ext_s;
      held_valid_r <= 1'b1;
    end else if (push_s && push_rel_s && held_match_s) begin
      held_valid_r <= 1'b0;
    end else begin
      held_valid_r <= held_valid_r;
    end
  end
`else
  assign accept_s = push_s;
`endif

  // Sequencer state and prefix timeout counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      tmo_cnt_r <= {TW{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (bus.rx_valid || bus.rx_error || timeout_s || (state_r == ST_IDLE)) begin
        tmo_cnt_r <= {TW{1'b0}};
      end else begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end
    end
  end

  // FIFO control and the next show-ahead head entry.
  always_comb begin
    pop_s        = (count_r != {CW{1'b0}}) && bus.event_ready;
    full_s       = (count_r == FULL_CNT);
    wr_ok_s      = accept_s && (!full_s || pop_s);
    drop_s       = accept_s && full_s && !pop_s;
    count_next_s = count_r + CW'(wr_ok_s) - CW'(pop_s);
    remain_s     = count_r - CW'(pop_s);
    rd_next_s    = rd_ptr_r + AW'(pop_s);
    // Head comes from storage if anything survives the pop, otherwise from
    // the entry being written this cycle.
    if (remain_s != {CW{1'b0}}) begin
      head_next_s = mem_r[rd_next_s];
    end else if (wr_ok_s) begin
      head_next_s = entry_s;
    end else begin
      head_next_s = head_r;
    end
  end

  // FIFO storage, pointers, registered head and status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 10'd0;
      end
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      head_r      <= 10'd0;
      valid_r     <= 1'b0;
      overflow_r  <= 1'b0;
      seq_error_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= entry_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r    <= rd_next_s;
      count_r     <= count_next_s;
      head_r      <= head_next_s;
      valid_r     <= (count_next_s != {CW{1'b0}});
      seq_error_r <= bus.rx_error || timeout_s;
      // A drop in the same cycle as a clear request keeps the flag set.
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (bus.clear_overflow) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign bus.event_code     = head_r[9:2];
  assign bus.event_extended = head_r[1];
  assign bus.event_release  = head_r[0];
  assign bus.event_valid    = valid_r;
  assign bus.fifo_count     = count_r;
  assign bus.overflow       = overflow_r;
  assign bus.seq_error      = seq_error_r;

endmodule

// File: tb/tb_ps2_key_event_controller.sv
module tb_ps2_key_event_controller;
  localparam int DEPTH = 8;
  localparam int TO    = 64;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ps2_key_event_controller_if #(.FIFO_DEPTH(DEPTH)) bus();

  ps2_key_event_controller #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: event queue, pending prefixes, flags, held key
  ev_t        mq[$];
  bit         m_ext, m_brk, m_ovf, m_seq, m_hv, m_he;
  logic [7:0] m_hc;

  function automatic ev_t head_obs();
    return {bus.event_code, bus.event_extended, bus.event_release};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_seq = 0; m_hv = 0; m_he = 0; m_hc = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit have, output ev_t e);
    have = 0;
    e = '0;
    if (m_brk) begin
      have = 1; e = {b, m_ext, 1'b1};
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (!m_ext && (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
      have = 0;
    end else begin
      have = 1; e = {b, m_ext, 1'b0};
    end
    if (have) begin m_ext = 0; m_brk = 0; end
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (have) begin
      if (!e.rel) begin
        if (m_hv && m_hc == e.code && m_he == e.ext) have = 0;
        else begin m_hv = 1; m_hc = e.code; m_he = e.ext; end
      end else if (m_hv && m_hc == e.code && m_he == e.ext) begin
        m_hv = 0;
      end
    end
`endif
  endtask

  // One clock: update the model from the inputs seen at the edge, return at negedge
  task automatic tick();
    bit  pop, have, dropped;
    ev_t e;
    @(posedge clock);
    pop = (mq.size() != 0) && bus.event_ready;
    have = 0; dropped = 0; e = '0;
    if (bus.rx_error) begin m_ext = 0; m_brk = 0; end
    else if (bus.rx_valid) model_byte(bus.rx_data, have, e);
    if (pop) void'(mq.pop_front());
    if (have) begin
      if (mq.size() < DEPTH) mq.push_back(e);
      else begin dropped = 1; m_ovf = 1; end
    end
    if (!dropped && bus.clear_overflow) m_ovf = 0;
    m_seq = bus.rx_error;
    @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b; bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
  endtask

  task automatic pop_one();
    bus.event_ready = 1'b1;
    tick();
    bus.event_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (head_obs() !== 10'd0) begin n_fail++; $display("FAIL reset_head: got %h expected 000", head_obs()); end
    n_tests++;
    if ({bus.event_valid, bus.overflow, bus.seq_error} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.event_valid, bus.overflow, bus.seq_error});
    end
    n_tests++;
    if (bus.fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count); end
  endtask

  task automatic test_make_break();
    send_byte(8'h1C);
    n_tests++;
    if (bus.event_valid !== 1'b1 || head_obs() !== {8'h1C, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL make_latency: got valid=%b head=%h expected valid=1 head=%h", bus.event_valid, head_obs(), {8'h1C, 2'b00});
    end
    send_byte(8'hF0); send_byte(8'h1C);
    n_tests++;
    if (bus.fifo_count !== 4'd2) begin n_fail++; $display("FAIL make_break_count: got %0d expected 2", bus.fifo_count); end
    pop_one();
    n_tests++;
    if (head_obs() !== {8'h1C, 1'b0, 1'b1}) begin n_fail++; $display("FAIL break_event: got %h expected %h", head_obs(), {8'h1C, 2'b01}); end
    pop_one();
    n_tests++;
    if (bus.event_valid !== 1'b0) begin n_fail++; $display("FAIL make_break_drain: got valid=%b expected 0", bus.event_valid); end
  endtask

  task automatic test_extended();
    send_byte(8'hE0); send_byte(8'h75); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    n_tests++;
    if (bus.fifo_count !== 4'd2 || head_obs() !== {8'h75, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL ext_make: got count=%0d head=%h expected count=2 head=%h", bus.fifo_count, head_obs(), {8'h75, 2'b10});
    end
    pop_one();
    n_tests++;
    if (head_obs() !== {8'h75, 1'b1, 1'b1}) begin n_fail++; $display("FAIL ext_break: got %h expected %h", head_obs(), {8'h75, 2'b11}); end
    pop_one();
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int first  = -1;
    send_byte(8'hE0);
    for (int i = 1; i <= TO + 8; i++) begin
      tick();
      if (bus.seq_error === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    m_ext = 0; m_brk = 0;
    n_tests++;
    if (pulses != 1 || first < TO - 1 || first > TO + 1) begin
      n_fail++; $display("FAIL timeout_pulse: got %0d pulses first at %0d expected 1 pulse near %0d", pulses, first, TO);
    end
    n_tests++;
    if (bus.fifo_count !== 4'd0) begin n_fail++; $display("FAIL timeout_nopush: got %0d expected 0", bus.fifo_count); end
    send_byte(8'h3A);
    n_tests++;
    if (head_obs() !== {8'h3A, 1'b0, 1'b0}) begin n_fail++; $display("FAIL timeout_next: got %h expected %h", head_obs(), {8'h3A, 2'b00}); end
    pop_one();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) send_byte(8'h15 + 8'(i));
    n_tests++;
    if (bus.fifo_count !== 4'd8 || bus.overflow !== 1'b1 || head_obs() !== {8'h15, 2'b00}) begin
      n_fail++; $display("FAIL ovf_full: got count=%0d ovf=%b head=%h expected 8 1 %h", bus.fifo_count, bus.overflow, head_obs(), {8'h15, 2'b00});
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (head_obs() !== {8'h15 + 8'(i), 2'b00}) begin n_fail++; $display("FAIL ovf_drain_%0d: got %h expected %h", i, head_obs(), {8'h15 + 8'(i), 2'b00}); end
      pop_one();
    end
    n_tests++;
    if (bus.event_valid !== 1'b0 || bus.overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_empty: got valid=%b ovf=%b expected 0 1", bus.event_valid, bus.overflow);
    end
    bus.clear_overflow = 1'b1; tick(); bus.clear_overflow = 1'b0;
    n_tests++;
    if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow); end
    for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i));
    bus.event_ready = 1'b1; send_byte(8'h28); bus.event_ready = 1'b0;
    n_tests++;
    if (bus.fifo_count !== 4'd8 || bus.overflow !== 1'b0 || head_obs() !== {8'h21, 2'b00}) begin
      n_fail++; $display("FAIL full_push_pop: got count=%0d ovf=%b head=%h expected 8 0 %h", bus.fifo_count, bus.overflow, head_obs(), {8'h21, 2'b00});
    end
    bus.clear_overflow = 1'b1; send_byte(8'h29); bus.clear_overflow = 1'b0;
    n_tests++;
    if (bus.overflow !== 1'b1 || bus.fifo_count !== 4'd8) begin
      n_fail++; $display("FAIL ovf_set_wins: got ovf=%b count=%0d expected 1 8", bus.overflow, bus.fifo_count);
    end
    bus.clear_overflow = 1'b1; tick(); bus.clear_overflow = 1'b0;
    bus.event_ready = 1'b1; repeat (8) tick(); bus.event_ready = 1'b0;
    n_tests++;
    if (bus.event_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_final: got valid=%b ovf=%b expected 0 0", bus.event_valid, bus.overflow);
    end
  endtask

  task automatic test_error_ignore();
    send_byte(8'hF0);
    bus.rx_data = 8'h33; bus.rx_valid = 1'b1; bus.rx_error = 1'b1;
    tick();
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.rx_error = 1'b0;
    n_tests++;
    if (bus.seq_error !== 1'b1 || bus.fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL err_pulse: got seq=%b count=%0d expected 1 0", bus.seq_error, bus.fifo_count);
    end
    tick();
    n_tests++;
    if (bus.seq_error !== 1'b0) begin n_fail++; $display("FAIL err_one_cycle: got %b expected 0", bus.seq_error); end
    send_byte(8'h2D);
    n_tests++;
    if (head_obs() !== {8'h2D, 2'b00}) begin n_fail++; $display("FAIL err_prefix_lost: got %h expected %h", head_obs(), {8'h2D, 2'b00}); end
    pop_one();
    send_byte(8'hFA);
    n_tests++;
    if (bus.event_valid !== 1'b0 || bus.fifo_count !== 4'd0) begin
      n_fail++; $display("FAIL ack_ignored: got valid=%b count=%0d expected 0 0", bus.event_valid, bus.fifo_count);
    end
  endtask

  task automatic test_typematic();
    ev_t exp_q[$];
    exp_q.push_back({8'h12, 2'b00});
`ifndef PS2_TYPEMATIC_FILTER_EN
    exp_q.push_back({8'h12, 2'b00});
    exp_q.push_back({8'h12, 2'b00});
`endif
    exp_q.push_back({8'h12, 2'b01});
    exp_q.push_back({8'h12, 2'b00});
    send_byte(8'h12); send_byte(8'h12); send_byte(8'h12);
    send_byte(8'hF0); send_byte(8'h12); send_byte(8'h12);
    n_tests++;
    if (bus.fifo_count !== 4'(exp_q.size())) begin
      n_fail++; $display("FAIL typematic_count: got %0d expected %0d", bus.fifo_count, exp_q.size());
    end
    foreach (exp_q[i]) begin
      n_tests++;
      if (head_obs() !== exp_q[i]) begin n_fail++; $display("FAIL typematic_ev_%0d: got %h expected %h", i, head_obs(), exp_q[i]); end
      pop_one();
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h1B); send_byte(8'h22); send_byte(8'hE0);
    reset = 1'b0;
    #2;
    model_reset();
    n_tests++;
    if (bus.fifo_count !== 4'd0 || bus.event_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got count=%0d valid=%b expected 0 0", bus.fifo_count, bus.event_valid);
    end
    @(negedge clock);
    reset = 1'b1;
    send_byte(8'h1C);
    n_tests++;
    if (head_obs() !== {8'h1C, 2'b00} || bus.fifo_count !== 4'd1) begin
      n_fail++; $display("FAIL reset_mid_prefix: got head=%h count=%0d expected %h 1", head_obs(), bus.fifo_count, {8'h1C, 2'b00});
    end
    pop_one();
  endtask

  task automatic test_random();
    logic [7:0] pool [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h6B, 8'h74, 8'hFA, 8'hAA};
    for (int i = 0; i < 900; i++) begin
      n_tests++;
      if (bus.event_valid !== (mq.size() != 0) || bus.fifo_count !== 4'(mq.size())) begin
        n_fail++; $display("FAIL rand_occupancy@%0d: got valid=%b count=%0d expected count=%0d", i, bus.event_valid, bus.fifo_count, mq.size());
      end
      n_tests++;
      if (bus.overflow !== m_ovf || bus.seq_error !== m_seq) begin
        n_fail++; $display("FAIL rand_flags@%0d: got ovf=%b seq=%b expected %b %b", i, bus.overflow, bus.seq_error, m_ovf, m_seq);
      end
      if (mq.size() != 0) begin
        n_tests++;
        if (head_obs() !== mq[0]) begin n_fail++; $display("FAIL rand_head@%0d: got %h expected %h", i, head_obs(), mq[0]); end
      end
      case ($urandom_range(0, 9))
        0, 1:    bus.rx_data = 8'hE0;
        2, 3:    bus.rx_data = 8'hF0;
        default: bus.rx_data = pool[$urandom_range(0, 7)];
      endcase
      bus.rx_valid       = ($urandom_range(0, 2) != 0);
      bus.rx_error       = ($urandom_range(0, 29) == 0);
      bus.clear_overflow = ($urandom_range(0, 15) == 0);
      bus.event_ready    = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      if (i >= 880) begin
        bus.rx_valid = 1'b0; bus.rx_error = 1'b0; bus.event_ready = 1'b1;
      end
      tick();
    end
    bus.rx_valid = 1'b0; bus.rx_error = 1'b0; bus.clear_overflow = 1'b0; bus.event_ready = 1'b0;
    n_tests++;
    if (bus.event_valid !== 1'b0 || mq.size() != 0) begin
      n_fail++; $display("FAIL rand_drained: got valid=%b model=%0d expected 0 0", bus.event_valid, mq.size());
    end
  endtask

  initial begin
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.rx_error = 1'b0;
    bus.event_ready = 1'b0; bus.clear_overflow = 1'b0;
    model_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b1;
    @(negedge clock);
    test_make_break();
    test_extended();
    test_timeout();
    test_overflow();
    test_error_ignore();
    test_typematic();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
